// File: rtl/nn_param_loader.sv
// Parameter-loading controller: one command channel plus a valid/ready beat stream fill an
// off-line staging register, which is committed atomically into one bank of the live parameters.
module nn_param_loader #(
  parameter int unsigned IN_W      = 2,
  parameter int unsigned NUM_BANKS = 5,
  parameter int unsigned LEN_W     = 16,
  parameter logic [NUM_BANKS*LEN_W-1:0] BANK_LENS = {16'd60, 16'd48, 16'd15, 16'd9, 16'd160},
  // Must equal the sum of BANK_LENS; checked at elaboration.
  parameter int unsigned TOTAL     = 292,
  localparam int unsigned SEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SEL_W-1:0]     cmd_bank,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 abort,
  output logic [TOTAL-1:0]     params_out,
  output logic [NUM_BANKS-1:0] bank_valid,
  output logic                 busy,
  output logic                 load_done,
  output logic                 err
);

  function automatic int unsigned len_of(input int unsigned b);
    return 32'(BANK_LENS[b*LEN_W +: LEN_W]);
  endfunction

  function automatic int unsigned off_of(input int unsigned b);
    int unsigned acc;
    acc = 0;
    for (int unsigned i = 0; i < b; i++) begin
      acc += len_of(i);
    end
    return acc;
  endfunction

  function automatic int unsigned max_len();
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (len_of(i) > m) m = len_of(i);
    end
    return m;
  endfunction

  function automatic int unsigned beats_of(input int unsigned b);
    return (len_of(b) + IN_W - 1) / IN_W;
  endfunction

  localparam int unsigned MaxLen   = max_len();
  localparam int unsigned MaxBeats = (MaxLen + IN_W - 1) / IN_W;
  // Staging holds whole beats; surplus top bits of the first beat are simply never committed.
  localparam int unsigned StgW     = MaxBeats * IN_W;
  localparam int unsigned CntW     = $clog2(MaxBeats + 1);

  if (off_of(NUM_BANKS) != TOTAL) begin : g_bad_total
    $error("TOTAL does not match the sum of BANK_LENS");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     bank_q, bank_d;
  logic [CntW-1:0]      beats_q, beats_d;
  logic [StgW-1:0]      stage_q, stage_d;
  logic [TOTAL-1:0]     params_q, params_d;
  logic [NUM_BANKS-1:0] bank_valid_q, bank_valid_d;
  logic                 load_done_q, load_done_d;
  logic                 err_q, err_d;

  function automatic logic [CntW-1:0] beats_for(input logic [SEL_W-1:0] sel);
    logic [CntW-1:0] n;
    n = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (sel == SEL_W'(b)) n = CntW'(beats_of(b));
    end
    return n;
  endfunction

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    beats_d      = beats_q;
    stage_d      = stage_q;
    bank_valid_d = bank_valid_q;
    load_done_d  = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (32'(cmd_bank) >= NUM_BANKS) begin
            err_d = 1'b1;
          end else begin
            bank_d  = cmd_bank;
            beats_d = beats_for(cmd_bank);
            stage_d = '0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        // Abort outranks a beat arriving in the same cycle, including the last one.
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          stage_d = StgW'({stage_q, in_data});
          beats_d = beats_q - 1'b1;
          if (beats_q == CntW'(1)) state_d = StCommit;
        end
      end
      StCommit: begin
        bank_valid_d[bank_q] = 1'b1;
        load_done_d          = 1'b1;
        state_d              = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Each bank slice either takes the staged value on its commit cycle or holds.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam int unsigned Len = len_of(b);
    localparam int unsigned Off = off_of(b);
    if (Len == 0) begin : g_bad_len
      $error("zero-length bank is not allowed");
    end else begin : g_slice
      assign params_d[Off +: Len] = (state_q == StCommit && bank_q == SEL_W'(b)) ?
                                    stage_q[Len-1:0] : params_q[Off +: Len];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bank_q       <= '0;
      beats_q      <= '0;
      stage_q      <= '0;
      params_q     <= '0;
      bank_valid_q <= '0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      beats_q      <= beats_d;
      stage_q      <= stage_d;
      params_q     <= params_d;
      bank_valid_q <= bank_valid_d;
      load_done_q  <= load_done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign in_ready   = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign params_out = params_q;
  assign bank_valid = bank_valid_q;
  assign load_done  = load_done_q;
  assign err        = err_q;

endmodule
